// File: rtl/issue_scoreboard_ctrl_if.sv
// Fetch / issue / execute / writeback bundle for issue_scoreboard_ctrl.
//
// Handshake semantics: a transfer happens on a rising clock edge when both
// sides of a pair are high in the cycle before that edge. The pairs are
// if_valid/id_ready (fetch -> issue) and iss_valid/ex_ready (issue -> execute).
// A valid that has not been taken holds its payload stable. The ready side
// may depend combinationally on the valid side. wb_valid, wb_flags and
// ex_flush are single-cycle strobes and have no ready.
//
// Modports:
//   master : the issue controller (drives id_ready, iss_valid, iss_instr)
//   slave  : fetch/execute/writeback environment
interface issue_scoreboard_ctrl_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        iss_valid;
    logic [31:0] iss_instr;
    logic        ex_ready;
    logic        ex_flush;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic        wb_flags;

    modport master (
        input  if_valid, if_instr, ex_ready, ex_flush, wb_valid, wb_reg, wb_flags,
        output id_ready, iss_valid, iss_instr
    );

    modport slave (
        output if_valid, if_instr, ex_ready, ex_flush, wb_valid, wb_reg, wb_flags,
        input  id_ready, iss_valid, iss_instr
    );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller between fetch and ID/execute.
// Holds one decoded instruction in an issue register. Fetch is stalled on
// RAW/WAW hazards against an 8-entry register scoreboard and a flags busy bit.
// A taken-branch flush drops the issue register; HALT parks the core until reset.
//
// Optional feature: define WB_BYPASS_EN to let the hazard check see the
// same-cycle writeback clear, so a dependent instruction issues in the
// writeback cycle instead of one cycle later.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus            fetch/issue/execute/writeback bundle (master side)
//   halted         HALT issued and drained
//   stall_cnt      saturating count of cycles with if_valid, RUN and !id_ready
//   state_dbg      FSM state (0 RUN, 1 FLUSH, 2 HALTED)
//   sb_dbg         register scoreboard
//   flag_busy_dbg  flags busy bit
module issue_scoreboard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    issue_scoreboard_ctrl_if.master bus,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             state_dbg,
    output logic [7:0]             sb_dbg,
    output logic                   flag_busy_dbg
);
    localparam int FCW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALTED = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [FCW-1:0]   flush_cnt, flush_cnt_nxt;
    logic [7:0]       sb, sb_nxt, sb_chk, wb_clr;
    logic             flag_busy, flag_busy_nxt, fb_chk;
    logic             iss_valid;
    logic [31:0]      iss_instr;
    logic [7:0]       iss_wmask;
    logic             iss_wflag;

    // Decode of the presented fetch word
    logic [1:0] cls;
    logic [4:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] rmask, wmask;
    logic       rflag, sflag, is_halt;
    logic       hazard, id_ready, accept, xfer, drop;
    logic       unused_bits;

    assign cls = bus.if_instr[31:30];
    assign op  = bus.if_instr[29:25];
    assign rd  = bus.if_instr[24:22];
    assign rs1 = bus.if_instr[21:19];
    assign rs2 = bus.if_instr[18:16];
    assign unused_bits = ^bus.if_instr[15:0];

    always_comb begin
        rmask   = 8'b0;
        wmask   = 8'b0;
        rflag   = 1'b0;
        sflag   = 1'b0;
        is_halt = 1'b0;
        case (cls)
            2'b00: begin
                wmask = 8'b1 << rd;
                if (op[4] || (op inside {5'b00100, 5'b00101, 5'b00010, 5'b00011}))
                    rmask = rmask | (8'b1 << rs1);
                // MOVT merges into its destination, so it reads it too
                if (op == 5'b00001)
                    rmask = rmask | (8'b1 << rd);
                sflag = (op[4:3] == 2'b11);
            end
            2'b01: begin
                wmask = 8'b1 << rd;
                rmask = 8'b1 << rs1;
                if (op != 5'b10110)
                    rmask = rmask | (8'b1 << rs2);
                sflag = (op[4:3] == 2'b11);
            end
            2'b10: begin
                if (!op[0]) begin
                    wmask = 8'b1 << rd;
                    rmask = 8'b1 << rs1;
                end else begin
                    rmask = (8'b1 << rd) | (8'b1 << rs1);
                end
            end
            default: begin
                if (op[3:0] == 4'b0001)
                    rflag = 1'b1;
                else if (op[3:0] == 4'b0010)
                    rmask = 8'b1 << rs1;
                else if (op[3])
                    is_halt = 1'b1;
            end
        endcase
    end

    assign wb_clr = bus.wb_valid ? (8'b1 << bus.wb_reg) : 8'b0;

`ifdef WB_BYPASS_EN
    assign sb_chk = sb & ~wb_clr;
    assign fb_chk = flag_busy & ~bus.wb_flags;
`else
    assign sb_chk = sb;
    assign fb_chk = flag_busy;
`endif

    assign hazard = (|((rmask | wmask) & sb_chk)) | ((rflag | sflag) & fb_chk);

    // FSM next state and id_ready
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        id_ready      = 1'b0;
        case (state)
            RUN: begin
                id_ready = !bus.ex_flush && !hazard && (!iss_valid || bus.ex_ready);
                if (bus.ex_flush) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end else if (bus.if_valid && id_ready && is_halt) begin
                    state_nxt = HALTED;
                end
            end
            FLUSH: begin
                if (bus.ex_flush) begin
                    flush_cnt_nxt = FLUSH_LOAD;
                end else begin
                    flush_cnt_nxt = flush_cnt - FCW'(1);
                    if (flush_cnt <= FCW'(1))
                        state_nxt = RUN;
                end
            end
            HALTED: begin
                // Only a HALT still sitting in the issue register can be flushed
                if (bus.ex_flush && iss_valid) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign accept = bus.if_valid & id_ready;
    assign xfer   = iss_valid & bus.ex_ready;
    // Flush beats a same-cycle transfer: the entry is dropped, not executed
    assign drop   = bus.ex_flush & iss_valid;

    // Clears first, then sets, so a same-cycle set of one bit wins
    assign sb_nxt = (sb & ~wb_clr & ~(drop ? iss_wmask : 8'b0)) | (accept ? wmask : 8'b0);
    assign flag_busy_nxt = (flag_busy & ~bus.wb_flags & ~(drop & iss_wflag)) | (accept & sflag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            sb        <= 8'b0;
            flag_busy <= 1'b0;
            iss_valid <= 1'b0;
            iss_instr <= 32'b0;
            iss_wmask <= 8'b0;
            iss_wflag <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            sb        <= sb_nxt;
            flag_busy <= flag_busy_nxt;
            if (drop) begin
                iss_valid <= 1'b0;
            end else if (accept) begin
                iss_valid <= 1'b1;
                iss_instr <= bus.if_instr;
                iss_wmask <= wmask;
                iss_wflag <= sflag;
            end else if (xfer) begin
                iss_valid <= 1'b0;
            end
            if (bus.if_valid && (state == RUN) && !id_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.id_ready  = id_ready;
    assign bus.iss_valid = iss_valid;
    assign bus.iss_instr = iss_instr;
    assign halted        = (state == HALTED) && !iss_valid;
    assign state_dbg     = state;
    assign sb_dbg        = sb;
    assign flag_busy_dbg = flag_busy;
endmodule
